// File: rtl/mem_pkg.sv
// Shared types and address-check helpers for the memory responder slice.
package mem_pkg;

  // Responder handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte offset bits below the word index.
  localparam int WORD_OFS = 2;

  // Number of word-index bits for a power-of-two word depth.
  function automatic int index_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

  // Wait counter width: log2(wait_cycles+1), never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM. The read register only updates when
// re is high, so the last load result is held across later writes.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IW = index_width(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Storage write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[index] <= wdata;
    end
  end

  // Registered read port, loaded only on request.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[index];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-port slave for the multicycle core: accepts one word access at a
// time, inserts WAIT_CYCLES wait states, then pulses ready for one cycle
// with registered read data or an error flag.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err
);

  localparam int IW = index_width(DEPTH_WORDS);
  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam int HW = 32 - IW - WORD_OFS;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic          NO_WAIT   = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            accept_s;

  logic            we_r;
  logic            bad_r;
  logic [IW-1:0]   idx_r;
  logic [31:0]     wdata_r;

  logic            ready_r;
  logic            err_r;
  logic            zero_r;

  logic            adr_bad_s;
  logic [IW-1:0]   adr_idx_s;
  logic            cur_we_s;
  logic            cur_bad_s;
  logic [IW-1:0]   cur_idx_s;
  logic            enter_resp_s;
  logic            ram_we_s;
  logic            ram_re_s;
  logic [31:0]     ram_rdata_s;

  // Address check for the request currently on the port.
  always_comb begin
    adr_bad_s = (adr[WORD_OFS-1:0] != 2'b00) ||
                (adr[31:IW+WORD_OFS] != {HW{1'b0}});
    adr_idx_s = adr[IW+WORD_OFS-1:WORD_OFS];
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          cnt_s    = WAIT_LOAD;
          if (NO_WAIT) begin
            state_s = RESP;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        // A count of 0 here cannot happen normally; leave rather than stick.
        if (cnt_r <= CNT_ONE) begin
          state_s = RESP;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = WAIT;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // View of the active transaction: port values in IDLE, captured ones later.
  always_comb begin
    if (state_r == IDLE) begin
      cur_we_s  = we;
      cur_bad_s = adr_bad_s;
      cur_idx_s = adr_idx_s;
    end else begin
      cur_we_s  = we_r;
      cur_bad_s = bad_r;
      cur_idx_s = idx_r;
    end
    enter_resp_s = (state_s == RESP) && (state_r != RESP);
    // Reset abandons the transaction: no load, no store.
    ram_re_s = reset && enter_resp_s && !cur_we_s && !cur_bad_s;
    ram_we_s = reset && (state_r == RESP) && we_r && !bad_r;
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Capture the request at acceptance; it stays fixed until completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_r    <= 1'b0;
      bad_r   <= 1'b0;
      idx_r   <= {IW{1'b0}};
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      we_r    <= we;
      bad_r   <= adr_bad_s;
      idx_r   <= adr_idx_s;
      wdata_r <= writedata;
    end
  end

  // Response flags; zero_r forces readdata low after reset or an error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      ready_r <= enter_resp_s;
      err_r   <= enter_resp_s && cur_bad_s;
      if (enter_resp_s && cur_bad_s) begin
        zero_r <= 1'b1;
      end else if (enter_resp_s && !cur_we_s) begin
        zero_r <= 1'b0;
      end
    end
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .index (cur_idx_s),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  assign readdata = zero_r ? 32'h0000_0000 : ram_rdata_s;
  assign ready    = ready_r;
  assign err      = err_r;

endmodule
